spi_cmd_arbiter: RTL and testbench
==================================

# spi_cmd_arbiter

Round-robin command arbiter and sequencer in front of `spi_master_v2`. It accepts SPI transfer commands from NREQ independent requesters over valid/ready handshakes and stages one command at a time. It hands each command to the master through the `driver_read`/`master_en` interlock, supplies the per-slave SPI mode, and returns a tagged response to the owning requester when the transfer completes.

## Interface
Parameters:
- NREQ, 4, number of requesters (2..8)
- CMD_W, DWIDTH+AWIDTH+5, command width (DWIDTH, AWIDTH from spi_pkg)

Command layout, identical to master `driver_data`:
- [0] write
- [2:1] size: 00 = 8 bits, 01 = 16 bits, 10 = 32 bits, 11 = illegal
- [CMD_W-3:3] payload, passed through unmodified
- [CMD_W-1:CMD_W-2] slave select (ss)

Ports:
- clk  in  1  clock
- rst_n  in  1  reset, asynchronous, active-low
- req_valid  in  NREQ  per-requester command valid
- req_cmd  in  NREQ×CMD_W  per-requester command
- req_ready  out  NREQ  accept strobe, one-hot or zero
- rsp_valid  out  1  response strobe, one cycle
- rsp_id  out  $clog2(NREQ)  owning requester
- rsp_err  out  1  command rejected (illegal size)
- rsp_data  out  DWIDTH  read data; 0 for writes and errors
- cfg_we  in  1  mode-table write enable
- cfg_ss  in  2  mode-table entry
- cfg_mode  in  2  {cpol,cpha}
- master_en  out  1  to master `master_en`
- driver_data  out  CMD_W  to master `driver_data`
- driver_cfg  out  2  to master `driver_cfg`
- driver_read  in  1  from master: ready for next command / previous transfer done
- spi_slv_data  in  DWIDTH  from master: read result, valid while `driver_read`=1

## Operation
- **Stage register.** Holds `stg_cmd`, `stg_id`, `stg_valid`.
  - Free when `stg_valid`=0.
  - Filled by round-robin grant: search starts at `rr_ptr`; on grant, `rr_ptr` becomes grant+1 mod NREQ.
  - `req_ready[g]`=1 combinationally in the grant cycle only. Requesters hold valid and cmd until ready.
- **Illegal size (11).** The command is accepted (ready pulses) but never staged. It sets `err_pend` with its id. While `err_pend`=1, no grants.
- **FSM states: IDLE, HANDOFF, BUSY.**
  - **IDLE:** `master_en`=`stg_valid`. If `stg_valid` and `driver_read` → HANDOFF.
  - **HANDOFF** (exactly 1 cycle; master is in LOAD):
    - `master_en`=1 and `driver_data` held.
    - At the end of the cycle, latch `act_id`, `act_write`, `act_mode`; clear `stg_valid`.
    - → BUSY.
  - **BUSY:**
    - `master_en` = ~`driver_read` | `stg_valid`.
    - On `driver_read`=1 (completion): register the response `rsp_id`=`act_id`, `rsp_data` = `act_write` ? 0 : `spi_slv_data`.
    - Then, if `stg_valid` → HANDOFF, else → IDLE (master parks with `master_en`=0).
- **Stage fill timing.** The stage may fill in IDLE or BUSY (prefetch), never in HANDOFF.
- **`driver_data`** = `stg_cmd` in IDLE/HANDOFF; holds last value in BUSY.
- **`driver_cfg`:**
  - `act_mode` in BUSY when `driver_read`=0.
  - Otherwise `mode_tbl[stg_cmd.ss]`, so cpha is valid when the master preloads SCK phase.
- **Mode table:** 4×2 bits. `cfg_we` writes `mode_tbl[cfg_ss]` at the next edge. Writes never affect an in-flight transfer, because `act_mode` is latched.
- **Response priority.** A completion response wins. `err_pend` issues on the first cycle with no completion response (`rsp_err`=1, `rsp_data`=0), then clears.

## Timing
- Reset values: state IDLE; `stg_valid`, `err_pend`, `rr_ptr`, `mode_tbl` = 0; all outputs 0 (`master_en`=0, `req_ready`=0, `rsp_*`=0, `driver_data`=0, `driver_cfg`=0).
- Grant → earliest HANDOFF: next cycle, if the master is parked with `driver_read`=1.
- Completion (`driver_read` edge in BUSY) → `rsp_valid`: 1 cycle (registered).
- Back-to-back transfers: with a prefetched stage, HANDOFF follows the completion cycle directly. No idle master cycle is inserted.
- Illegal command → `rsp_valid`: 1 cycle if no collision, otherwise delayed 1 cycle per colliding completion.
- Reset mid-transfer: the master shares `rst_n`. Staged, active and pending-error commands are discarded; no response is issued.

## Structure
- spi_pkg gains:
  - `CMD_W`
  - the `arb_state_t` enum (IDLE, HANDOFF, BUSY)
  - a command field-position localparam set (WR_BIT, SIZE_LSB, SS_LSB)
  - `SIZE_ILLEGAL`=2'b11
- One sub-module, `rr_arbiter` (NREQ, req vector + `rr_ptr` → one-hot grant + index), reusable elsewhere.

## Test plan
- **Single write.** Reset; req0 write, size 00, ss 2; `mode_tbl[2]`=2'b01.
  - Expect `req_ready[0]` one cycle and one HANDOFF with `driver_cfg`=01.
  - On completion, expect `rsp_valid`, `rsp_id`=0, `rsp_data`=0.
- **Read.** req1 read, size 10; master returns `spi_slv_data`=32'hDEADBEEF on completion.
  - Expect `rsp_id`=1, `rsp_data`=32'hDEADBEEF.
- **Round-robin fairness.** All 4 requesters held valid continuously.
  - Expect grants 0,1,2,3,0,… and back-to-back HANDOFFs with no IDLE between transfers.
- **Illegal size.** req2 size 11 while a transfer is in BUSY and completes the same cycle.
  - Expect the completion response first, then `rsp_err`=1 with `rsp_id`=2.
  - The illegal command is never handed off.
- **Mode stability.** `cfg_we` to the active slave's entry during BUSY.
  - Expect `driver_cfg` unchanged until completion; the new mode applies to the next transfer.
- **Reset mid-operation.** Assert `rst_n`=0 in BUSY with a staged command.
  - Expect all outputs 0 and no `rsp_valid` after release.

Source files
------------

// File: rtl/spi_pkg.sv
// Shared SPI definitions: datapath widths, command field positions and arbiter state encoding.
package spi_pkg;

  localparam int DWIDTH = 32;
  localparam int AWIDTH = 8;
  localparam int CMD_W  = DWIDTH + AWIDTH + 5;

  // Command field positions (ss occupies the top two bits of the command)
  localparam int WR_BIT   = 0;
  localparam int SIZE_LSB = 1;
  localparam int SS_LSB   = CMD_W - 2;

  localparam logic [1:0] SIZE_ILLEGAL = 2'b11;

  typedef enum logic [1:0] {
    IDLE,
    HANDOFF,
    BUSY
  } arb_state_t;

endpackage

// File: rtl/spi_cmd_arbiter_rr.sv
// Round-robin arbiter: picks the first asserted request at or after ptr, wrapping at NREQ.
module rr_arbiter #(
  parameter  int NREQ = 4,
  localparam int IW   = $clog2(NREQ)
) (
  input  logic [NREQ-1:0] req,
  input  logic [IW-1:0]   ptr,
  output logic [NREQ-1:0] gnt,
  output logic [IW-1:0]   idx,
  output logic            any
);

  always_comb begin
    int unsigned j;
    j   = 0;
    gnt = '0;
    idx = '0;
    any = 1'b0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      j = (32'(ptr) + i) % NREQ;
      if (!any && req[j]) begin
        gnt[j] = 1'b1;
        idx    = IW'(j);
        any    = 1'b1;
      end
    end
  end

endmodule

// File: rtl/spi_cmd_arbiter.sv
// Round-robin command arbiter and sequencer in front of spi_master_v2; stages one command,
// hands it off through the driver_read/master_en interlock and returns a tagged response.
module spi_cmd_arbiter import spi_pkg::*; #(
  parameter  int NREQ  = 4,
  parameter  int CMD_W = spi_pkg::CMD_W,
  localparam int IW    = $clog2(NREQ)
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [NREQ-1:0]            req_valid,
  input  logic [NREQ-1:0][CMD_W-1:0] req_cmd,
  output logic [NREQ-1:0]            req_ready,
  output logic                       rsp_valid,
  output logic [IW-1:0]              rsp_id,
  output logic                       rsp_err,
  output logic [DWIDTH-1:0]          rsp_data,
  input  logic                       cfg_we,
  input  logic [1:0]                 cfg_ss,
  input  logic [1:0]                 cfg_mode,
  output logic                       master_en,
  output logic [CMD_W-1:0]           driver_data,
  output logic [1:0]                 driver_cfg,
  input  logic                       driver_read,
  input  logic [DWIDTH-1:0]          spi_slv_data
);

  arb_state_t        state;
  logic              stg_valid;
  logic [CMD_W-1:0]  stg_cmd;
  logic [IW-1:0]     stg_id;
  logic [IW-1:0]     rr_ptr;
  logic              err_pend;
  logic [IW-1:0]     err_id;
  logic [IW-1:0]     act_id;
  logic              act_write;
  logic [1:0]        act_mode;
  logic [CMD_W-1:0]  held_cmd;
  logic [3:0][1:0]   mode_tbl;

  logic [NREQ-1:0]   gnt;
  logic [IW-1:0]     gnt_idx;
  logic              gnt_any;
  logic              grant_en;
  logic              accept;
  logic              done;
  logic [CMD_W-1:0]  gnt_cmd;
  logic [1:0]        stg_ss;

  rr_arbiter #(.NREQ(NREQ)) u_rr (
    .req (req_valid),
    .ptr (rr_ptr),
    .gnt (gnt),
    .idx (gnt_idx),
    .any (gnt_any)
  );

  // ss is taken from the top of the command so it follows the CMD_W override
  assign stg_ss    = stg_cmd[CMD_W-1 -: 2];
  assign gnt_cmd   = req_cmd[gnt_idx];
  assign grant_en  = !stg_valid && !err_pend && (state != HANDOFF);
  assign accept    = grant_en && gnt_any;
  assign req_ready = grant_en ? gnt : '0;
  assign done      = (state == BUSY) && driver_read;

  always_comb begin
    master_en = 1'b0;
    case (state)
      IDLE:    master_en = stg_valid;
      HANDOFF: master_en = 1'b1;
      BUSY:    master_en = !driver_read || stg_valid;
      default: master_en = 1'b0;
    endcase
  end

  assign driver_data = (state == BUSY) ? held_cmd : stg_cmd;
  // Outside an active transfer the staged slave's mode is shown so cpha is ready at preload
  assign driver_cfg  = ((state == BUSY) && !driver_read) ? act_mode : mode_tbl[stg_ss];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      stg_valid <= 1'b0;
      stg_cmd   <= '0;
      stg_id    <= '0;
      rr_ptr    <= '0;
      err_pend  <= 1'b0;
      err_id    <= '0;
      act_id    <= '0;
      act_write <= 1'b0;
      act_mode  <= '0;
      held_cmd  <= '0;
      mode_tbl  <= '0;
      rsp_valid <= 1'b0;
      rsp_id    <= '0;
      rsp_err   <= 1'b0;
      rsp_data  <= '0;
    end else begin
      rsp_valid <= 1'b0;
      rsp_err   <= 1'b0;

      if (cfg_we)
        mode_tbl[cfg_ss] <= cfg_mode;

      if (accept) begin
        rr_ptr <= (gnt_idx == IW'(NREQ - 1)) ? '0 : gnt_idx + 1'b1;
        if (gnt_cmd[SIZE_LSB +: 2] == SIZE_ILLEGAL) begin
          err_pend <= 1'b1;
          err_id   <= gnt_idx;
        end else begin
          stg_valid <= 1'b1;
          stg_cmd   <= gnt_cmd;
          stg_id    <= gnt_idx;
        end
      end

      case (state)
        IDLE: begin
          if (stg_valid && driver_read)
            state <= HANDOFF;
        end
        HANDOFF: begin
          act_id    <= stg_id;
          act_write <= stg_cmd[WR_BIT];
          act_mode  <= mode_tbl[stg_ss];
          held_cmd  <= stg_cmd;
          stg_valid <= 1'b0;
          state     <= BUSY;
        end
        BUSY: begin
          if (driver_read) begin
            rsp_valid <= 1'b1;
            rsp_id    <= act_id;
            rsp_data  <= act_write ? '0 : spi_slv_data;
            state     <= stg_valid ? HANDOFF : IDLE;
          end
        end
        default: state <= IDLE;
      endcase

      // A completion response takes the slot; the pending error waits for a free one
      if (err_pend && !done) begin
        rsp_valid <= 1'b1;
        rsp_err   <= 1'b1;
        rsp_id    <= err_id;
        rsp_data  <= '0;
        err_pend  <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_spi_cmd_arbiter.sv
// Directed bench for spi_cmd_arbiter; the bench plays the SPI master by driving driver_read.
module tb_spi_cmd_arbiter;
  import spi_pkg::*;

  localparam int NREQ = 4;
  localparam int CW   = spi_pkg::CMD_W;

  logic                    clk = 1'b0;
  logic                    rst_n;
  logic [NREQ-1:0]         req_valid;
  logic [NREQ-1:0][CW-1:0] req_cmd;
  logic [NREQ-1:0]         req_ready;
  logic                    rsp_valid;
  logic [1:0]              rsp_id;
  logic                    rsp_err;
  logic [DWIDTH-1:0]       rsp_data;
  logic                    cfg_we;
  logic [1:0]              cfg_ss;
  logic [1:0]              cfg_mode;
  logic                    master_en;
  logic [CW-1:0]           driver_data;
  logic [1:0]              driver_cfg;
  logic                    driver_read;
  logic [DWIDTH-1:0]       spi_slv_data;

  int errors = 0;
  int checks = 0;
  logic [CW-1:0] c0, c1, c3, c2bad, c4, c5, c6;

  always #5 clk = ~clk;

  spi_cmd_arbiter #(.NREQ(NREQ), .CMD_W(CW)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .req_valid    (req_valid),
    .req_cmd      (req_cmd),
    .req_ready    (req_ready),
    .rsp_valid    (rsp_valid),
    .rsp_id       (rsp_id),
    .rsp_err      (rsp_err),
    .rsp_data     (rsp_data),
    .cfg_we       (cfg_we),
    .cfg_ss       (cfg_ss),
    .cfg_mode     (cfg_mode),
    .master_en    (master_en),
    .driver_data  (driver_data),
    .driver_cfg   (driver_cfg),
    .driver_read  (driver_read),
    .spi_slv_data (spi_slv_data)
  );

  function automatic logic [CW-1:0] mk(input logic [1:0] ss, input logic [CW-6:0] pl,
                                       input logic [1:0] size, input logic wr);
    return {ss, pl, size, wr};
  endfunction

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_rsp(input string tag, input logic v, input logic [1:0] id,
                         input logic err, input logic [31:0] data);
    chk({tag, "_valid"}, 64'(rsp_valid), 64'(v));
    chk({tag, "_id"},    64'(rsp_id),    64'(id));
    chk({tag, "_err"},   64'(rsp_err),   64'(err));
    chk({tag, "_data"},  64'(rsp_data),  64'(data));
  endtask

  initial begin
    req_valid    = '0;
    req_cmd      = '0;
    cfg_we       = 1'b0;
    cfg_ss       = '0;
    cfg_mode     = '0;
    driver_read  = 1'b0;
    spi_slv_data = '0;
    rst_n        = 1'b0;
    repeat (2) step();

    chk("rst_master_en", 64'(master_en), 0);
    chk("rst_req_ready", 64'(req_ready), 0);
    chk_rsp("rst_rsp", 1'b0, 2'd0, 1'b0, 32'd0);
    chk("rst_driver_data", 64'(driver_data), 0);
    chk("rst_driver_cfg", 64'(driver_cfg), 0);

    rst_n       = 1'b1;
    driver_read = 1'b1;
    cfg_we = 1'b1; cfg_ss = 2'd2; cfg_mode = 2'b01;
    step();
    cfg_ss = 2'd1; cfg_mode = 2'b10;
    step();
    cfg_we = 1'b0;

    // Single write from req0 to slave 2
    c0 = mk(2'd2, 40'h12345, 2'b00, 1'b1);
    req_valid = 4'b0001; req_cmd[0] = c0; #1;
    chk("w_ready", 64'(req_ready), 4'b0001);
    chk("w_en_empty", 64'(master_en), 0);
    step();
    req_valid = '0; #1;
    chk("w_ready_drop", 64'(req_ready), 0);
    chk("w_idle_en", 64'(master_en), 1);
    chk("w_idle_data", 64'(driver_data), 64'(c0));
    chk("w_idle_cfg", 64'(driver_cfg), 2'b01);
    step();
    chk("w_ho_en", 64'(master_en), 1);
    chk("w_ho_data", 64'(driver_data), 64'(c0));
    chk("w_ho_cfg", 64'(driver_cfg), 2'b01);
    driver_read = 1'b0;
    step();
    chk("w_busy_en", 64'(master_en), 1);
    chk("w_busy_cfg", 64'(driver_cfg), 2'b01);
    chk("w_busy_rsp", 64'(rsp_valid), 0);
    step();
    driver_read = 1'b1; spi_slv_data = 32'hCAFEF00D; #1;
    chk("w_done_en", 64'(master_en), 0);
    step();
    chk_rsp("w_rsp", 1'b1, 2'd0, 1'b0, 32'd0);
    step();
    chk("w_rsp_pulse", 64'(rsp_valid), 0);

    // Read from req1, size 32
    c1 = mk(2'd0, 40'hA5, 2'b10, 1'b0);
    req_valid = 4'b0010; req_cmd[1] = c1; #1;
    chk("r_ready", 64'(req_ready), 4'b0010);
    step();
    req_valid = '0;
    step();
    chk("r_ho_data", 64'(driver_data), 64'(c1));
    driver_read = 1'b0;
    step();
    step();
    driver_read = 1'b1; spi_slv_data = 32'hDEADBEEF;
    step();
    chk_rsp("r_rsp", 1'b1, 2'd1, 1'b0, 32'hDEADBEEF);

    // Round robin with all requesters valid; pointer now at 2
    for (int i = 0; i < NREQ; i++) req_cmd[i] = mk(2'd0, 40'(i + 16), 2'b00, 1'b1);
    req_valid = '1; #1;
    chk("rr_first", 64'(req_ready), 4'b0100);
    step();
    chk("rr_full", 64'(req_ready), 0);
    chk("rr_idle_en", 64'(master_en), 1);
    step();
    for (int t = 0; t < 4; t++) begin
      int h;
      h = (2 + t) % 4;
      chk("rr_ho_data", 64'(driver_data), 64'(req_cmd[h]));
      chk("rr_ho_en", 64'(master_en), 1);
      chk("rr_ho_ready", 64'(req_ready), 0);
      if (t > 0) chk_rsp("rr_rsp", 1'b1, 2'((h + 3) % 4), 1'b0, 32'd0);
      driver_read = 1'b0;
      step();
      chk("rr_grant", 64'(req_ready), 64'(1) << ((h + 1) % 4));
      step();
      driver_read = 1'b1; #1;
      chk("rr_prefetch_en", 64'(master_en), 1);
      step();
    end
    req_valid = '0;
    chk("rr_tail_data", 64'(driver_data), 64'(req_cmd[2]));
    chk_rsp("rr_tail_rsp", 1'b1, 2'd1, 1'b0, 32'd0);
    driver_read = 1'b0;
    step();
    chk("rr_tail_noreq", 64'(req_ready), 0);
    driver_read = 1'b1;
    step();
    chk_rsp("rr_tail_done", 1'b1, 2'd2, 1'b0, 32'd0);

    // Illegal size from req2 accepted in the completion cycle of req3's transfer
    c3    = mk(2'd1, 40'h33, 2'b00, 1'b1);
    c2bad = mk(2'd0, 40'h22, 2'b11, 1'b0);
    c4    = mk(2'd1, 40'h44, 2'b00, 1'b1);
    req_valid = 4'b1000; req_cmd[3] = c3; #1;
    chk("il_ready3", 64'(req_ready), 4'b1000);
    step();
    req_valid = '0;
    step();
    driver_read = 1'b0;
    step();
    req_valid = 4'b0100; req_cmd[2] = c2bad; driver_read = 1'b1; #1;
    chk("il_accept", 64'(req_ready), 4'b0100);
    step();
    req_valid = 4'b0001; req_cmd[0] = c4; #1;
    chk_rsp("il_first_done", 1'b1, 2'd3, 1'b0, 32'd0);
    chk("il_block", 64'(req_ready), 0);
    chk("il_no_ho", 64'(master_en), 0);
    step();
    chk_rsp("il_err", 1'b1, 2'd2, 1'b1, 32'd0);
    chk("il_regrant", 64'(req_ready), 4'b0001);

    // Mode change to the active slave during BUSY
    step();
    req_valid = '0; #1;
    chk("ms_idle_cfg", 64'(driver_cfg), 2'b10);
    step();
    chk("ms_ho_data", 64'(driver_data), 64'(c4));
    driver_read = 1'b0;
    step();
    cfg_we = 1'b1; cfg_ss = 2'd1; cfg_mode = 2'b11; #1;
    chk("ms_busy_cfg0", 64'(driver_cfg), 2'b10);
    step();
    cfg_we = 1'b0; #1;
    chk("ms_busy_cfg1", 64'(driver_cfg), 2'b10);
    step();
    chk("ms_busy_cfg2", 64'(driver_cfg), 2'b10);
    driver_read = 1'b1;
    step();
    chk_rsp("ms_rsp", 1'b1, 2'd0, 1'b0, 32'd0);
    c5 = mk(2'd1, 40'h55, 2'b00, 1'b0);
    req_valid = 4'b0010; req_cmd[1] = c5; #1;
    chk("ms2_ready", 64'(req_ready), 4'b0010);
    step();
    req_valid = '0; #1;
    chk("ms2_idle_cfg", 64'(driver_cfg), 2'b11);
    step();
    driver_read = 1'b0;
    step();
    chk("ms2_busy_cfg", 64'(driver_cfg), 2'b11);

    // Reset while BUSY with a prefetched command
    c6 = mk(2'd2, 40'h66, 2'b00, 1'b1);
    req_valid = 4'b0100; req_cmd[2] = c6; #1;
    chk("rst_prefetch", 64'(req_ready), 4'b0100);
    step();
    req_valid = '0; #1;
    chk("rst_staged_en", 64'(master_en), 1);
    rst_n = 1'b0; driver_read = 1'b1; #1;
    chk("mid_rst_master_en", 64'(master_en), 0);
    chk("mid_rst_req_ready", 64'(req_ready), 0);
    chk_rsp("mid_rst_rsp", 1'b0, 2'd0, 1'b0, 32'd0);
    chk("mid_rst_driver_data", 64'(driver_data), 0);
    chk("mid_rst_driver_cfg", 64'(driver_cfg), 0);
    step();
    rst_n = 1'b1;
    for (int k = 0; k < 4; k++) begin
      step();
      chk("post_rst_rsp", 64'(rsp_valid), 0);
      chk("post_rst_en", 64'(master_en), 0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
